// File: rtl/lock_pkg.sv
// Shared types and helpers for the two-button lock supervisor: display state
// encoding, press-to-digit mapping and the timer width calculation.
package lock_pkg;

    typedef enum logic [2:0] {
        ST_ENTRY   = 3'd0,
        ST_CHECK   = 3'd1,
        ST_OPEN    = 3'd2,
        ST_LOCKOUT = 3'd3,
        ST_PROG    = 3'd4
    } state_e;

    localparam logic DIGIT_B0 = 1'b0;
    localparam logic DIGIT_B1 = 1'b1;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // One timer serves the open window, lockout and entry timeout, so it is
    // sized for the longest of the three.
    function automatic int timer_width(input int a, input int b, input int c);
        return $clog2(max3(a, b, c) + 1);
    endfunction

    function automatic logic press_digit(input logic is_b1);
        return is_b1 ? DIGIT_B1 : DIGIT_B0;
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter that stops at zero; shared by the open window,
// lockout period and partial-entry timeout of lock_supervisor.
module lock_timer #(
    parameter int TW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    input  logic          en,
    output logic [TW-1:0] cnt,
    output logic          zero
);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - TW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign zero = (cnt_q == '0);

endmodule

// File: rtl/lock_supervisor.sv
// Two-button code lock sequencer: press capture, code check, unlock window and
// failure lockout. Define LOCK_PROG_EN to add the prog port and code reprogramming.
module lock_supervisor
    import lock_pkg::*;
#(
    parameter int                  CODE_LEN = 4,
    parameter logic [CODE_LEN-1:0] CODE     = 4'b0101,
    parameter int                  OPEN_CYC = 8,
    parameter int                  MAX_FAIL = 3,
    parameter int                  LOCK_CYC = 16,
    parameter int                  ENTRY_TO = 10,
    localparam int                 FW       = $clog2(MAX_FAIL + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          b0,
    input  logic          b1,
`ifdef LOCK_PROG_EN
    input  logic          prog,
`endif
    output logic          unlc,
    output logic          lockout,
    output logic [FW-1:0] fail_cnt,
    output logic [2:0]    st
);

    localparam int                TW        = timer_width(OPEN_CYC, LOCK_CYC, ENTRY_TO);
    localparam int                CW        = $clog2(CODE_LEN + 1);
    localparam logic [CW-1:0]     LAST_IDX  = CW'(CODE_LEN - 1);
    localparam logic [FW-1:0]     FAIL_MAX  = FW'(MAX_FAIL);
    localparam logic [FW-1:0]     FAIL_LAST = FW'(MAX_FAIL - 1);

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [CODE_LEN-1:0] shift_q, shift_d;
    logic [FW-1:0]       fail_q, fail_d;
    logic                b0_q, b1_q;
    logic                unlc_q, unlc_d;
    logic                lockout_q, lockout_d;

    logic                press0, press1, abort, single, digit;
    logic [CODE_LEN-1:0] shift_next;
    logic [CODE_LEN-1:0] ref_code;

    logic                tmr_load;
    logic [TW-1:0]       tmr_load_val;
    logic                tmr_en;
    logic [TW-1:0]       tmr_cnt;
    logic                tmr_zero;

`ifdef LOCK_PROG_EN
    logic [CODE_LEN-1:0] code_q, code_d;
    assign ref_code = code_q;
`else
    assign ref_code = CODE;
`endif

    assign press0 = b0 & ~b0_q;
    assign press1 = b1 & ~b1_q;
    assign abort  = press0 & press1;
    assign single = press0 ^ press1;
    assign digit  = press_digit(press1);

    always_comb begin
        shift_next    = shift_q << 1;
        shift_next[0] = digit;
    end

    lock_timer #(
        .TW(TW)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (tmr_load),
        .load_val(tmr_load_val),
        .en      (tmr_en),
        .cnt     (tmr_cnt),
        .zero    (tmr_zero)
    );

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        fail_d       = fail_q;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        tmr_en       = 1'b0;
`ifdef LOCK_PROG_EN
        code_d       = code_q;
`endif

        unique case (state_q)
            ST_ENTRY: begin
                if (abort) begin
                    cnt_d   = '0;
                    shift_d = '0;
                end else if (single) begin
                    shift_d      = shift_next;
                    tmr_load     = 1'b1;
                    tmr_load_val = TW'(ENTRY_TO);
                    if (cnt_q == LAST_IDX) begin
                        cnt_d   = '0;
                        state_d = ST_CHECK;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else if (cnt_q != '0) begin
                    // Discard on the idle cycle that takes the timer to zero.
                    tmr_en = 1'b1;
                    if (tmr_cnt <= TW'(1)) begin
                        cnt_d   = '0;
                        shift_d = '0;
                    end
                end
            end

            ST_CHECK: begin
                if (shift_q == ref_code) begin
                    state_d      = ST_OPEN;
                    tmr_load     = 1'b1;
                    tmr_load_val = TW'(OPEN_CYC - 1);
                    fail_d       = '0;
                end else if (fail_q == FAIL_LAST) begin
                    state_d      = ST_LOCKOUT;
                    tmr_load     = 1'b1;
                    tmr_load_val = TW'(LOCK_CYC - 1);
                    fail_d       = FAIL_MAX;
                end else begin
                    state_d = ST_ENTRY;
                    fail_d  = fail_q + FW'(1);
                end
            end

            ST_OPEN: begin
                tmr_en = 1'b1;
                if (abort) begin
                    state_d = ST_ENTRY;
`ifdef LOCK_PROG_EN
                end else if (prog) begin
                    state_d = ST_PROG;
                    cnt_d   = '0;
`endif
                end else if (tmr_zero) begin
                    state_d = ST_ENTRY;
                end
            end

            ST_LOCKOUT: begin
                tmr_en = 1'b1;
                if (tmr_zero) begin
                    state_d = ST_ENTRY;
                    fail_d  = '0;
                end
            end

`ifdef LOCK_PROG_EN
            ST_PROG: begin
                if (abort) begin
                    state_d = ST_ENTRY;
                    cnt_d   = '0;
                end else if (single) begin
                    shift_d = shift_next;
                    if (cnt_q == LAST_IDX) begin
                        code_d  = shift_next;
                        cnt_d   = '0;
                        state_d = ST_ENTRY;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
`endif

            default: begin
                state_d = ST_ENTRY;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        unlc_d    = (state_d == ST_OPEN);
`ifdef LOCK_PROG_EN
        unlc_d    = unlc_d | (state_d == ST_PROG);
`endif
        lockout_d = (state_d == ST_LOCKOUT);
    end

    // NOTE: state flops use non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_ENTRY;
            cnt_q     <= '0;
            shift_q   <= '0;
            fail_q    <= '0;
            b0_q      <= 1'b0;
            b1_q      <= 1'b0;
            unlc_q    <= 1'b0;
            lockout_q <= 1'b0;
`ifdef LOCK_PROG_EN
            code_q    <= CODE;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            fail_q    <= fail_d;
            b0_q      <= b0;
            b1_q      <= b1;
            unlc_q    <= unlc_d;
            lockout_q <= lockout_d;
`ifdef LOCK_PROG_EN
            code_q    <= code_d;
`endif
        end
    end

    assign unlc     = unlc_q;
    assign lockout  = lockout_q;
    assign fail_cnt = fail_q;
    assign st       = state_q;

endmodule

// File: tb/tb_lock_supervisor.sv
// Self-checking bench for lock_supervisor (default parameters) with a
// transaction-level reference model; LOCK_PROG_EN adds the reprogramming scenario.
module tb_lock_supervisor;

    localparam int CODE_LEN = 4;
    localparam int OPEN_CYC = 8;
    localparam int MAX_FAIL = 3;
    localparam int LOCK_CYC = 16;
    localparam int ENTRY_TO = 10;

    logic       clk = 1'b0;
    logic       rst;
    logic       b0;
    logic       b1;
    logic       unlc;
    logic       lockout;
    logic [1:0] fail_cnt;
    logic [2:0] st;
`ifdef LOCK_PROG_EN
    logic       prog;
    bit         drv_prog = 1'b0;
    assign prog = drv_prog;
`endif

    always #5 clk = ~clk;

    lock_supervisor dut (
        .clk     (clk),
        .rst     (rst),
        .b0      (b0),
        .b1      (b1),
`ifdef LOCK_PROG_EN
        .prog    (prog),
`endif
        .unlc    (unlc),
        .lockout (lockout),
        .fail_cnt(fail_cnt),
        .st      (st)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;
    int unlc_seen = 0;
    int lock_seen = 0;

    // Reference model: mode uses the display numbering (0 entry .. 4 prog).
    int m_mode, m_fails, m_idle, m_left, m_code, m_entered;
    int m_digits[$];
    bit m_prev0, m_prev1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pack_digits();
        int v = 0;
        foreach (m_digits[i]) v = v * 2 + m_digits[i];
        return v;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_fails = 0; m_idle = 0; m_left = 0;
        m_code = 5; m_entered = 0;
        m_digits.delete();
        m_prev0 = 1'b0; m_prev1 = 1'b0;
    endtask

    task automatic model_step(input bit v0, input bit v1);
        bit p0, p1, ab, sg;
        p0 = v0 && !m_prev0;
        p1 = v1 && !m_prev1;
        m_prev0 = v0;
        m_prev1 = v1;
        ab = p0 && p1;
        sg = p0 ^ p1;
        case (m_mode)
            0: begin
                if (ab) m_digits.delete();
                else if (sg) begin
                    m_digits.push_back(int'(p1));
                    m_idle = 0;
                    if (m_digits.size() == CODE_LEN) begin
                        m_entered = pack_digits();
                        m_digits.delete();
                        m_mode = 1;
                    end
                end else if (m_digits.size() > 0) begin
                    m_idle++;
                    if (m_idle >= ENTRY_TO) m_digits.delete();
                end
            end
            1: begin
                if (m_entered == m_code) begin
                    m_mode = 2; m_left = OPEN_CYC; m_fails = 0;
                end else if (m_fails + 1 == MAX_FAIL) begin
                    m_mode = 3; m_left = LOCK_CYC; m_fails = MAX_FAIL;
                end else begin
                    m_fails++; m_mode = 0;
                end
            end
            2: begin
                if (ab) m_mode = 0;
`ifdef LOCK_PROG_EN
                else if (drv_prog) begin
                    m_mode = 4;
                    m_digits.delete();
                end
`endif
                else begin
                    m_left--;
                    if (m_left == 0) m_mode = 0;
                end
            end
            3: begin
                m_left--;
                if (m_left == 0) begin
                    m_mode = 0; m_fails = 0;
                end
            end
            4: begin
                if (ab) begin
                    m_mode = 0;
                    m_digits.delete();
                end else if (sg) begin
                    m_digits.push_back(int'(p1));
                    if (m_digits.size() == CODE_LEN) begin
                        m_code = pack_digits();
                        m_digits.delete();
                        m_mode = 0;
                    end
                end
            end
            default: m_mode = 0;
        endcase
    endtask

    // Compare process: every settled cycle against the model.
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("st", int'(st), m_mode);
            check("unlc", int'(unlc), int'(m_mode == 2 || m_mode == 4));
            check("lockout", int'(lockout), int'(m_mode == 3));
            check("fail_cnt", int'(fail_cnt), m_fails);
        end
    end

    task automatic step(input bit v0, input bit v1);
        b0 = v0;
        b1 = v1;
        @(posedge clk);
        #1;
        model_step(v0, v1);
        unlc_seen += int'(unlc);
        lock_seen += int'(lockout);
    endtask

    task automatic press(input int d);
        step(d == 0, d == 1);
        step(1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    task automatic enter4(input int d0, input int d1, input int d2, input int d3);
        press(d0); press(d1); press(d2); press(d3);
    endtask

    // Asynchronous reset mid-cycle, checked before the next clock edge.
    task automatic async_reset(input string tag);
        chk_en = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check({tag, "_st"}, int'(st), 0);
        check({tag, "_unlc"}, int'(unlc), 0);
        check({tag, "_lockout"}, int'(lockout), 0);
        check({tag, "_fail"}, int'(fail_cnt), 0);
        model_reset();
        #3;
        rst = 1'b0;
        chk_en = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        b0  = 1'b0;
        b1  = 1'b0;
        model_reset();
        #3;
        check("rst_st", int'(st), 0);
        check("rst_unlc", int'(unlc), 0);
        check("rst_lockout", int'(lockout), 0);
        check("rst_fail", int'(fail_cnt), 0);
        #9;
        rst = 1'b0;
        chk_en = 1'b1;

        // 1: correct code on consecutive cycles, CHECK then 8 open cycles.
        step(1, 0); step(0, 1); step(1, 0); step(0, 1);
        check("t1_check_st", int'(st), 1);
        check("t1_check_unlc", int'(unlc), 0);
        unlc_seen = 0;
        idle(12);
        check("t1_open_cycles", unlc_seen, 8);
        check("t1_st_back", int'(st), 0);
        check("t1_fail", int'(fail_cnt), 0);

        // 2: three wrong entries -> lockout, presses ignored, then reopen.
        enter4(1, 1, 1, 1);
        check("t2_fail1", int'(fail_cnt), 1);
        enter4(1, 1, 1, 1);
        check("t2_fail2", int'(fail_cnt), 2);
        unlc_seen = 0; lock_seen = 0;
        enter4(1, 1, 1, 1);
        check("t2_lock_st", int'(st), 3);
        check("t2_lock_fail", int'(fail_cnt), 3);
        enter4(0, 1, 0, 1);
        idle(12);
        check("t2_lock_cycles", lock_seen, 16);
        check("t2_no_unlc", unlc_seen, 0);
        check("t2_fail_cleared", int'(fail_cnt), 0);
        unlc_seen = 0;
        enter4(0, 1, 0, 1);
        idle(10);
        check("t2_reopen_cycles", unlc_seen, 8);

        // 3: 10 idle cycles discard a partial entry; 9 do not.
        press(0); press(1); idle(9);
        press(0); press(1);
        check("t3_discarded", int'(st), 0);
        press(0); press(1);
        check("t3_opens", int'(st), 2);
        idle(10);
        press(0); press(1); idle(8);
        press(0); press(1);
        check("t3_kept_9", int'(st), 2);
        check("t3_fail", int'(fail_cnt), 0);
        idle(10);

        // 4: ABORT mid-entry and in OPEN.
        press(0); press(1);
        step(1, 1); step(0, 0);
        press(0); press(1);
        check("t4_abort_entry", int'(st), 0);
        press(0); press(1);
        check("t4_opens", int'(st), 2);
        press(1);
        check("t4_single_ignored", int'(unlc), 1);
        step(1, 1);
        check("t4_abort_open_st", int'(st), 0);
        check("t4_abort_open_unlc", int'(unlc), 0);
        step(0, 0);
        idle(3);

        // 5: asynchronous reset during OPEN and during LOCKOUT.
        enter4(0, 1, 0, 1);
        idle(2);
        async_reset("t5_open");
        idle(2);
        enter4(0, 0, 0, 0);
        enter4(0, 0, 0, 0);
        enter4(0, 0, 0, 0);
        idle(3);
        check("t5_in_lockout", int'(lockout), 1);
        async_reset("t5_lock");
        idle(2);

`ifdef LOCK_PROG_EN
        // 6: reprogram to 1100 from OPEN.
        enter4(0, 1, 0, 1);
        drv_prog = 1'b1;
        step(0, 0);
        drv_prog = 1'b0;
        check("t6_prog_st", int'(st), 4);
        check("t6_prog_unlc", int'(unlc), 1);
        press(1); press(1); press(0); step(1, 0);
        check("t6_prog_done", int'(st), 0);
        step(0, 0);
        enter4(0, 1, 0, 1);
        check("t6_old_fails", int'(fail_cnt), 1);
        enter4(1, 1, 0, 0);
        check("t6_new_opens", int'(st), 2);
        idle(10);
`endif

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
